// File: rtl/rpm_pkg.sv
// Shared constants, widths and FSM encoding for the RPM blip generator.
package rpm_pkg;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BLIP_NUM = 8;
  localparam int unsigned BLIP_DEN = 3;

  localparam int unsigned RPM_W = 16;
  localparam int unsigned HP_W  = 24;

  // Clocks per half blip period at 1 RPM: CLK_HZ*DEN / (2*NUM).
  function automatic longint unsigned calc_k(input longint unsigned clk_hz,
                                             input longint unsigned num,
                                             input longint unsigned den);
    return (clk_hz * den) / (64'd2 * num);
  endfunction

  localparam longint unsigned K = calc_k(CLK_HZ, BLIP_NUM, BLIP_DEN);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    COMMIT
  } cmd_state_e;

endpackage

// File: rtl/rpm_divider.sv
// Restoring divider: 24-bit dividend / 16-bit divisor, one quotient bit per
// clock. The start edge already performs the first iteration, so done pulses
// on the 24th edge after start is taken.
module rpm_divider
  import rpm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [HP_W-1:0]  dividend_i,
  input  logic [RPM_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [HP_W-1:0]  quotient_o
);

  localparam int unsigned CNT_W = $clog2(HP_W);

  logic [RPM_W-1:0] rem_q, rem_d, rem_in;
  logic [RPM_W-1:0] div_q, div_in;
  logic [HP_W-1:0]  quo_q, quo_d, quo_in;
  logic [CNT_W-1:0] left_q;
  logic             busy_q, done_q;
  logic [RPM_W:0]   trial;
  logic             qbit;

  // One restoring-division step, fed from the ports on start, else from state.
  always_comb begin
    rem_in = start_i ? '0         : rem_q;
    quo_in = start_i ? dividend_i : quo_q;
    div_in = start_i ? divisor_i  : div_q;
    trial  = {rem_in, quo_in[HP_W-1]};
    qbit   = 1'b0;
    rem_d  = trial[RPM_W-1:0];
    if (trial >= {1'b0, div_in}) begin
      qbit  = 1'b1;
      rem_d = RPM_W'(trial - {1'b0, div_in});
    end
    quo_d = {quo_in[HP_W-2:0], qbit};
  end

  // Iteration sequencing and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      left_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        div_q  <= divisor_i;
        left_q <= CNT_W'(HP_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        left_q <= left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/rpm_blip_gen.sv
// Commanded RPM to blip square wave. A command FSM computes the half-period
// with a sequential divide; the phase counter only adopts a new half-period
// at a phase boundary so no runt pulse is ever produced.
module rpm_blip_gen
  import rpm_pkg::*;
#(
  parameter int unsigned CLK_HZ   = rpm_pkg::CLK_HZ,
  parameter int unsigned BLIP_NUM = rpm_pkg::BLIP_NUM,
  parameter int unsigned BLIP_DEN = rpm_pkg::BLIP_DEN
) (
  input  logic             clk50M,
  input  logic             reset,
  input  logic [RPM_W-1:0] rpm_cmd,
  input  logic             rpm_valid,
  output logic             rpm_ready,
  output logic             blips,
  output logic             running,
  output logic [HP_W-1:0]  half_period
);

  localparam longint unsigned K_FULL = calc_k(CLK_HZ, BLIP_NUM, BLIP_DEN);
  localparam logic [HP_W-1:0] K_VAL  = HP_W'(K_FULL);

  // K must fit the dividend and exceed any divisor so H is never 0 for rpm>0.
  if (((K_FULL >> HP_W) != 0) || (K_FULL < (64'd1 << RPM_W))) begin : g_bad_k
    $error("rpm_blip_gen: K=%0d out of range for the divider widths", K_FULL);
  end

  cmd_state_e       state_q;
  logic             ready_q, zero_q;
  logic [HP_W-1:0]  pend_q;
  logic             pend_valid_q;

  logic [HP_W-1:0]  cnt_q, cnt_d, hp_q, hp_d;
  logic             blips_q, blips_d, running_q;
  logic             consume, commit, accept, div_start;
  logic             div_busy, div_done;
  logic [HP_W-1:0]  div_quo;

  assign accept    = rpm_valid && ready_q;
  assign div_start = accept && (rpm_cmd != '0) && !div_busy;
  assign commit    = (state_q == COMMIT);

  rpm_divider u_div (
    .clk_i      (clk50M),
    .rst_i      (reset),
    .start_i    (div_start),
    .dividend_i (K_VAL),
    .divisor_i  (rpm_cmd),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Command FSM: accept, divide (or skip for 0), commit to the pend register.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      zero_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            zero_q  <= (rpm_cmd == '0);
            state_q <= (rpm_cmd == '0) ? COMMIT : DIV;
          end
        end
        DIV: begin
          if (div_done) state_q <= COMMIT;
        end
        COMMIT: begin
          pend_q  <= zero_q ? '0 : div_quo;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pending flag: a fresh commit wins over a same-cycle consume, so the newer
  // value stays queued while the generator picks up the older one.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset)        pend_valid_q <= 1'b0;
    else if (commit)  pend_valid_q <= 1'b1;
    else if (consume) pend_valid_q <= 1'b0;
  end

  // Phase counter next-state: load from pend only when stopped or at a boundary.
  always_comb begin
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    blips_d = blips_q;
    consume = 1'b0;
    if (hp_q == '0) begin
      cnt_d   = '0;
      blips_d = 1'b0;
      if (pend_valid_q) begin
        hp_d    = pend_q;
        consume = 1'b1;
      end
    end else if (cnt_q == hp_q - HP_W'(1)) begin
      cnt_d   = '0;
      blips_d = ~blips_q;
      if (pend_valid_q) begin
        hp_d    = pend_q;
        consume = 1'b1;
        if (pend_q == '0) blips_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + HP_W'(1);
    end
  end

  // Phase counter and registered outputs.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hp_q      <= '0;
      blips_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      blips_q   <= blips_d;
      running_q <= (hp_d != '0);
    end
  end

  assign rpm_ready   = ready_q;
  assign blips       = blips_q;
  assign running     = running_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_rpm_blip_gen.sv
// Directed bench for rpm_blip_gen at default parameters (K = 9_375_000).
module tb_rpm_blip_gen;

  logic        clk50M = 1'b0;
  logic        reset;
  logic [15:0] rpm_cmd;
  logic        rpm_valid;
  logic        rpm_ready;
  logic        blips;
  logic        running;
  logic [23:0] half_period;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk50M = ~clk50M;

  rpm_blip_gen dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .rpm_cmd     (rpm_cmd),
    .rpm_valid   (rpm_valid),
    .rpm_ready   (rpm_ready),
    .blips       (blips),
    .running     (running),
    .half_period (half_period)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk50M);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rpm_valid = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic send_cmd(input logic [15:0] v, output int unsigned used);
    int unsigned w;
    w = 0;
    while (rpm_ready !== 1'b1 && w < 200) begin
      step(1);
      w++;
    end
    if (rpm_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_cmd_ready: rpm_ready=%b after %0d cycles, required 1", rpm_ready, w);
    end
    rpm_cmd   = v;
    rpm_valid = 1'b1;
    step(1);
    rpm_valid = 1'b0;
    used = w + 1;
  endtask

  task automatic wait_hp_change(input logic [23:0] from, input int unsigned bound,
                                output int unsigned n);
    n = 0;
    while (half_period === from && n < bound) begin
      step(1);
      n++;
    end
  endtask

  task automatic measure_phase(input int unsigned bound, output int unsigned len);
    logic lvl;
    lvl = blips;
    len = 0;
    do begin
      step(1);
      len++;
    end while (blips === lvl && len < bound);
  endtask

  task automatic test_reset();
    reset = 1'b1; rpm_valid = 1'b0; rpm_cmd = '0;
    step(3);
    vectors++; if (rpm_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, want 1", rpm_ready); end
    vectors++; if (blips !== 1'b0) begin miscompares++; $display("FAIL reset_blips: got %b, want 0", blips); end
    vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b, want 0", running); end
    vectors++; if (half_period !== 24'd0) begin miscompares++; $display("FAIL reset_hp: got %0d, want 0", half_period); end
    reset = 1'b0;
    step(3);
    vectors++; if (rpm_ready !== 1'b1 || running !== 1'b0 || half_period !== 24'd0) begin
      miscompares++; $display("FAIL idle_after_reset: ready=%b running=%b hp=%0d, want 1 0 0", rpm_ready, running, half_period);
    end
  endtask

  task automatic test_start_and_update();
    int unsigned used, low, n, hi, len;
    send_cmd(16'd1000, used);
    low = 0;
    while (rpm_ready === 1'b0 && low < 100) begin low++; step(1); end
    vectors++; if (low !== 25) begin miscompares++; $display("FAIL ready_low_cycles: got %0d, want 25", low); end
    vectors++; if (half_period !== 24'd0) begin miscompares++; $display("FAIL hp_before_load: got %0d, want 0", half_period); end
    step(1);
    vectors++; if (half_period !== 24'd9375) begin miscompares++; $display("FAIL hp_1000: got %0d, want 9375", half_period); end
    vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL running_1000: got %b, want 1", running); end
    n = 0;
    while (blips === 1'b0 && n < 20000) begin step(1); n++; end
    vectors++; if (n !== 9375) begin miscompares++; $display("FAIL first_rise: got %0d, want 9375", n); end
    // New command in the middle of the high phase.
    step(2000);
    hi = 2000;
    send_cmd(16'd2000, used);
    hi += used;
    while (blips === 1'b1 && hi < 20000) begin step(1); hi++; end
    vectors++; if (hi !== 9375) begin miscompares++; $display("FAIL old_high_len: got %0d, want 9375", hi); end
    vectors++; if (half_period !== 24'd4687) begin miscompares++; $display("FAIL hp_2000: got %0d, want 4687", half_period); end
    measure_phase(20000, len);
    vectors++; if (len !== 4687) begin miscompares++; $display("FAIL new_low_len: got %0d, want 4687", len); end
    measure_phase(20000, len);
    vectors++; if (len !== 4687) begin miscompares++; $display("FAIL new_high_len: got %0d, want 4687", len); end
  endtask

  // Entered right at the start of a low phase with H=4687.
  task automatic test_stop_low();
    int unsigned used, t;
    logic seen_high;
    seen_high = 1'b0;
    send_cmd(16'd0, used);
    t = used;
    while (running === 1'b1 && t < 20000) begin
      step(1);
      t++;
      if (blips !== 1'b0) seen_high = 1'b1;
    end
    vectors++; if (t !== 4687) begin miscompares++; $display("FAIL stop_low_at: got %0d, want 4687", t); end
    vectors++; if (seen_high !== 1'b0) begin miscompares++; $display("FAIL stop_low_blip: got %b, want 0", seen_high); end
    vectors++; if (half_period !== 24'd0) begin miscompares++; $display("FAIL stop_low_hp: got %0d, want 0", half_period); end
  endtask

  task automatic test_stop_high();
    int unsigned used, n, hi;
    send_cmd(16'd65535, used);
    n = 0;
    while (blips === 1'b0 && n < 500) begin step(1); n++; end
    vectors++; if (n !== 169) begin miscompares++; $display("FAIL rise_65535: got %0d, want 169", n); end
    send_cmd(16'd0, used);
    hi = used;
    while (blips === 1'b1 && hi < 500) begin step(1); hi++; end
    vectors++; if (hi !== 143) begin miscompares++; $display("FAIL stop_high_len: got %0d, want 143", hi); end
    vectors++; if (running !== 1'b0 || half_period !== 24'd0) begin
      miscompares++; $display("FAIL stop_high_state: running=%b hp=%0d, want 0 0", running, half_period);
    end
    step(300);
    vectors++; if (blips !== 1'b0) begin miscompares++; $display("FAIL stop_high_stays: got %b, want 0", blips); end
  endtask

  task automatic test_divide_values();
    int unsigned used, n;
    send_cmd(16'd65535, used);
    wait_hp_change(24'd0, 100, n);
    vectors++; if (half_period !== 24'd143) begin miscompares++; $display("FAIL hp_65535: got %0d, want 143", half_period); end
    vectors++; if (n !== 26) begin miscompares++; $display("FAIL load_latency: got %0d, want 26", n); end
    send_cmd(16'd3, used);
    wait_hp_change(24'd143, 400, n);
    vectors++; if (half_period !== 24'd3125000) begin miscompares++; $display("FAIL hp_3: got %0d, want 3125000", half_period); end
    do_reset();
    send_cmd(16'd1, used);
    wait_hp_change(24'd0, 100, n);
    vectors++; if (half_period !== 24'd9375000) begin miscompares++; $display("FAIL hp_1: got %0d, want 9375000", half_period); end
    do_reset();
    send_cmd(16'd7, used);
    wait_hp_change(24'd0, 100, n);
    vectors++; if (half_period !== 24'd1339285) begin miscompares++; $display("FAIL hp_7: got %0d, want 1339285", half_period); end
    do_reset();
  endtask

  task automatic test_reset_mid_div();
    int unsigned used, n;
    send_cmd(16'd65535, used);
    wait_hp_change(24'd0, 100, n);
    send_cmd(16'd7, used);
    step(10);
    #2 reset = 1'b1;
    #1;
    vectors++; if (rpm_ready !== 1'b1 || blips !== 1'b0 || running !== 1'b0 || half_period !== 24'd0) begin
      miscompares++;
      $display("FAIL async_reset: ready=%b blips=%b running=%b hp=%0d, want 1 0 0 0", rpm_ready, blips, running, half_period);
    end
    step(2);
    reset = 1'b0;
    step(1);
    send_cmd(16'd500, used);
    wait_hp_change(24'd0, 100, n);
    vectors++; if (half_period !== 24'd18750) begin miscompares++; $display("FAIL hp_500: got %0d, want 18750", half_period); end
  endtask

  task automatic test_handshake();
    int unsigned i, n;
    do_reset();
    rpm_cmd = 16'd3000;
    rpm_valid = 1'b1;
    step(1);
    i = 0;
    while (rpm_ready === 1'b0 && i < 100) begin
      rpm_cmd = 16'(5000 + i);
      step(1);
      i++;
    end
    vectors++; if (i !== 25) begin miscompares++; $display("FAIL held_valid_busy: got %0d, want 25", i); end
    rpm_cmd = 16'd2000;
    step(1);
    rpm_valid = 1'b0;
    vectors++; if (rpm_ready !== 1'b0) begin miscompares++; $display("FAIL second_accept: ready=%b, want 0", rpm_ready); end
    vectors++; if (half_period !== 24'd3125) begin miscompares++; $display("FAIL hp_3000: got %0d, want 3125", half_period); end
    wait_hp_change(24'd3125, 4000, n);
    vectors++; if (half_period !== 24'd4687 || n !== 3125) begin
      miscompares++; $display("FAIL hp_after_3000: hp=%0d at %0d, want 4687 at 3125", half_period, n);
    end
    step(5000);
    vectors++; if (half_period !== 24'd4687) begin miscompares++; $display("FAIL no_queued_cmd: got %0d, want 4687", half_period); end
  endtask

  task automatic test_back_to_back();
    int unsigned used, n, len;
    do_reset();
    send_cmd(16'd1000, used);
    wait_hp_change(24'd0, 100, n);
    send_cmd(16'd2000, used);
    send_cmd(16'd4000, used);
    wait_hp_change(24'd9375, 12000, n);
    vectors++; if (half_period !== 24'd2343) begin miscompares++; $display("FAIL b2b_latest: got %0d, want 2343", half_period); end
    measure_phase(5000, len);
    vectors++; if (len !== 2343 || half_period !== 24'd2343) begin
      miscompares++; $display("FAIL b2b_phase: len=%0d hp=%0d, want 2343 2343", len, half_period);
    end
  endtask

  initial begin
    reset = 1'b1;
    rpm_valid = 1'b0;
    rpm_cmd = '0;
    test_reset();
    test_start_and_update();
    test_stop_low();
    test_stop_high();
    test_divide_values();
    test_reset_mid_div();
    test_handshake();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
